axis_pkt_arbiter: RTL and testbench

Packet-level arbiter that shares one AXI stream datapath (typically an `axis_srl_fifo` input) among S_COUNT AXI stream sources. It grants one source at a time and holds the grant until that source's `tlast` beat is accepted. Beats pass through a registered output stage, and the granted source index is tagged onto `m_axis_tid`. It sits between multiple packet producers and a shared FIFO or egress path.

---
 rtl/axis_arb_pkg.sv | 46 ++++
 rtl/axis_arb_skid_reg.sv | 68 ++++++
 rtl/axis_pkt_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types and helpers for the AXI stream packet arbiter:
//               arbiter state encoding, select-width computation and the
//               wrapping priority selector.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    localparam int c_MAX_SOURCES = 16;
    localparam int c_SEL_MAX     = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_t;

    // Index width for n sources; a single source still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest requesting index at or above start; if none, wrap to the
    // lowest requesting index overall.
    function automatic logic [c_SEL_MAX-1:0] prio_select(
        input logic [c_MAX_SOURCES-1:0] req,
        input logic [c_SEL_MAX-1:0]     start
    );
        logic [c_MAX_SOURCES-1:0] masked;
        logic [c_SEL_MAX-1:0]     sel;
        masked = req & ~((c_MAX_SOURCES'(1) << start) - c_MAX_SOURCES'(1));
        if (masked == '0) begin
            masked = req;
        end
        sel = '0;
        for (int i = c_MAX_SOURCES - 1; i >= 0; i--) begin
            if (masked[i]) begin
                sel = c_SEL_MAX'(i);
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_arb_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_skid_reg
// Description : Two-entry registered stream stage (output register plus temp
//               register) with a registered upstream ready.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_arb_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_s_data,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_m_valid,
    input  logic             i_m_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_tmp_data;
    logic             r_out_valid;
    logic             r_tmp_valid;
    logic             r_s_ready;
    logic             w_s_ready_early;

    // Stay ready unless the temp slot is occupied or about to be filled.
    assign w_s_ready_early = i_m_ready || (!r_tmp_valid && (!r_out_valid || !i_s_valid));

    // Move beats input->output, input->temp on stall, temp->output on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_tmp_data  <= '0;
            r_out_valid <= 1'b0;
            r_tmp_valid <= 1'b0;
            r_s_ready   <= 1'b0;
        end else begin
            r_s_ready <= w_s_ready_early;
            if (r_s_ready) begin
                if (i_m_ready || !r_out_valid) begin
                    r_out_valid <= i_s_valid;
                    if (i_s_valid) begin
                        r_out_data <= i_s_data;
                    end
                end else begin
                    r_tmp_valid <= i_s_valid;
                    if (i_s_valid) begin
                        r_tmp_data <= i_s_data;
                    end
                end
            end else if (i_m_ready) begin
                r_out_valid <= r_tmp_valid;
                if (r_tmp_valid) begin
                    r_out_data <= r_tmp_data;
                end
                r_tmp_valid <= 1'b0;
            end
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_m_data  = r_out_data;
    assign o_m_valid = r_out_valid;

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_arbiter
// Description : Packet-level arbiter sharing one AXI stream among S_COUNT
//               sources. The grant is held until the granted source's tlast
//               beat is accepted; the source index is tagged onto tid.
//               Define AXIS_ARB_ROUND_ROBIN_EN for round-robin selection,
//               otherwise the lowest requesting index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             busy,
    output logic [sel_width(S_COUNT)-1:0]    grant_index
);

    localparam int SEL_WIDTH  = sel_width(S_COUNT);
    localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [SEL_WIDTH-1:0]   r_grant;
    logic [SEL_WIDTH-1:0]   w_grant_next;
    logic [c_SEL_MAX-1:0]   w_start;
    logic [c_SEL_MAX-1:0]   w_winner;
    logic                   w_any_req;
    logic                   w_in_valid;
    logic                   w_skid_ready;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [KEEP_WIDTH-1:0]  w_sel_keep;
    logic [DEST_WIDTH-1:0]  w_sel_dest;
    logic [USER_WIDTH-1:0]  w_sel_user;
    logic [BEAT_WIDTH-1:0]  w_in_beat;
    logic [BEAT_WIDTH-1:0]  w_out_beat;

    assign w_any_req = |s_axis_tvalid;
    assign w_winner  = prio_select(c_MAX_SOURCES'(s_axis_tvalid), w_start);

`ifdef AXIS_ARB_ROUND_ROBIN_EN
    logic [c_SEL_MAX-1:0] r_rr_ptr;

    // Rotate priority to the source just after each new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_rr_ptr <= (w_winner == c_SEL_MAX'(S_COUNT - 1)) ? '0 : w_winner + c_SEL_MAX'(1);
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    // Route the granted source's beat toward the output stage.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '1;
        w_sel_dest  = '0;
        w_sel_user  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (r_grant == SEL_WIDTH'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_keep  = KEEP_ENABLE ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] : '1;
                w_sel_dest  = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
                w_sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Arbiter state and grant register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    // Grant in IDLE; in PASS forward beats and release on the accepted tlast.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_in_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_next = w_winner[SEL_WIDTH-1:0];
                    w_state_next = ST_PASS;
                end
            end
            ST_PASS: begin
                w_in_valid = w_sel_valid;
                if (w_sel_valid && w_skid_ready && w_sel_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_ready
        assign s_axis_tready[gi] = (r_state == ST_PASS) && (r_grant == SEL_WIDTH'(gi)) && w_skid_ready;
    end

    assign w_in_beat = {w_sel_data, w_sel_keep, w_sel_last, ID_WIDTH'(r_grant), w_sel_dest, w_sel_user};

    axis_arb_skid_reg #(
        .WIDTH (BEAT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_s_data  (w_in_beat),
        .i_s_valid (w_in_valid),
        .o_s_ready (w_skid_ready),
        .o_m_data  (w_out_beat),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = w_out_beat;
    assign busy        = (r_state == ST_PASS);
    assign grant_index = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_arbiter
// Description : Self-checking bench for axis_pkt_arbiter: directed packet
//               scenarios plus a randomized contention run, all checked
//               against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_arbiter;

    localparam int S   = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  dest;
        logic [0:0]  user;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [0:0]  user;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    logic [S*DW-1:0]  s_axis_tdata;
    logic [S*KW-1:0]  s_axis_tkeep;
    logic [S-1:0]     s_axis_tvalid;
    logic [S-1:0]     s_axis_tready;
    logic [S-1:0]     s_axis_tlast;
    logic [S*DSW-1:0] s_axis_tdest;
    logic [S*UW-1:0]  s_axis_tuser;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [IW-1:0]    m_axis_tid;
    logic [DSW-1:0]   m_axis_tdest;
    logic [UW-1:0]    m_axis_tuser;
    logic             busy;
    logic [1:0]       grant_index;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(
        .S_COUNT    (S),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEST_WIDTH (DSW),
        .USER_WIDTH (UW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .grant_index   (grant_index)
    );

    // Source packet stores (head = next beat to present).
    beat_t mem [S][256];
    int    head [S];
    int    tail [S];
    bit    in_pkt [S];

    // Reference model state.
    out_t  exp_q[$];
    int    dut_order[$];
    bit    m_busy;
    int    m_grant;
    int    rr_ptr;
    bit    prev_stall;
    logic [90:0] prev_obs;

    int n_vectors;
    int n_miscompares;
    int cyc;
    int rdy_mode;
    int first_req;
    int first_out;
    int out_count;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending_src();
        for (int i = 0; i < S; i++) begin
            if (head[i] < tail[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Arbitration rule: first requester scanning from rr_ptr upward, wrapping.
    function automatic int pick(input logic [S-1:0] req);
        for (int k = 0; k < S; k++) begin
            if (req[(rr_ptr + k) % S]) return (rr_ptr + k) % S;
        end
        return 0;
    endfunction

    task automatic push_pkt(input int src, input int len, input logic [63:0] base, input logic [63:0] step);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + step * 64'(k);
            b.keep = 8'($urandom);
            b.last = (k == len - 1);
            b.dest = 8'($urandom);
            b.user = 1'($urandom);
            mem[src][tail[src]] = b;
            tail[src]++;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < S; i++) begin
            if (head[i] < tail[i]) begin
                b = mem[i][head[i]];
                s_axis_tvalid[i]           = 1'b1;
                s_axis_tdata[i*DW +: DW]   = b.data;
                s_axis_tkeep[i*KW +: KW]   = b.keep;
                s_axis_tlast[i]            = b.last;
                s_axis_tdest[i*DSW +: DSW] = b.dest;
                s_axis_tuser[i*UW +: UW]   = b.user;
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tlast[i]  = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_axis_tready = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    // One clock: check at the falling edge, then advance model and stimulus.
    task automatic tick();
        logic [S-1:0] acc;
        logic [S-1:0] allowed;
        logic [90:0]  obs_all;
        out_t         obs;
        out_t         e;
        beat_t        b;
        bit           nb;
        int           ng;
        @(negedge clk);
        cyc++;
        allowed = m_busy ? (S'(1) << m_grant) : '0;
        check("ready_outside_grant", 128'(s_axis_tready & ~allowed), 128'(0));
        check("busy", 128'(busy), 128'(m_busy));
        check("grant_index", 128'(grant_index), 128'(m_grant));
        obs     = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};
        obs_all = {m_axis_tvalid, obs};
        if (prev_stall) check("stall_hold", 128'(obs_all), 128'(prev_obs));
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_obs   = obs_all;
        if (s_axis_tvalid != '0 && first_req < 0) first_req = cyc;
        if (m_axis_tvalid && first_out < 0) first_out = cyc;
        if (m_axis_tvalid && m_axis_tready) begin
            out_count++;
            check("out_beat_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_beat", 128'(obs), 128'(e));
            end
        end
        acc = s_axis_tvalid & s_axis_tready;
        nb  = m_busy;
        ng  = m_grant;
        for (int i = 0; i < S; i++) begin
            if (acc[i]) begin
                b = mem[i][head[i]];
                exp_q.push_back({b.data, b.keep, b.last, 8'(i), b.dest, b.user});
                if (!in_pkt[i]) dut_order.push_back(i);
                in_pkt[i] = !b.last;
                if (b.last && m_busy && i == m_grant) nb = 1'b0;
            end
        end
        if (!m_busy && s_axis_tvalid != '0) begin
            ng = pick(s_axis_tvalid);
            nb = 1'b1;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
            rr_ptr = (ng + 1) % S;
`endif
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < S; i++) begin
            if (acc[i]) head[i]++;
        end
        m_busy  = nb;
        m_grant = ng;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((pending_src() || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(n < budget), 128'(1));
    endtask

    // Assert reset for one clock; sources abandon whatever they had queued.
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < S; i++) begin
            head[i]   = 0;
            tail[i]   = 0;
            in_pkt[i] = 1'b0;
        end
        exp_q.delete();
        m_busy     = 1'b0;
        m_grant    = 0;
        rr_ptr     = 0;
        prev_stall = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp3 [4];
    int start_head;
    int n;

    initial begin
        n_vectors = 0; n_miscompares = 0; cyc = 0; rdy_mode = 0;
        first_req = -1; first_out = -1; out_count = 0;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0;
        s_axis_tlast = '0; s_axis_tdest = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < S; i++) begin
            head[i] = 0; tail[i] = 0; in_pkt[i] = 1'b0;
        end
        m_busy = 1'b0; m_grant = 0; rr_ptr = 0; prev_stall = 1'b0; prev_obs = '0;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
        exp3 = '{0, 3, 0, 3};
`else
        exp3 = '{0, 0, 0, 0};
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 128'(m_axis_tvalid), 128'(0));
        check("rst_s_ready", 128'(s_axis_tready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant", 128'(grant_index), 128'(0));
        check("rst_payload", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();

        // Three-beat packet from source 0 with the sink always ready.
        dut_order.delete();
        push_pkt(0, 3, 64'h11, 64'h11);
        drive();
        drain("t1_drain", 50);
        check("t1_valid_to_output", 128'(first_out - first_req), 128'(2));
        check("t1_packets", 128'(dut_order.size()), 128'(1));

        // Sources 1 and 2 collide; packets must complete in order 1 then 2.
        dut_order.delete();
        push_pkt(1, 2, 64'hA000, 64'h1);
        push_pkt(2, 2, 64'hB000, 64'h1);
        drive();
        drain("t2_drain", 50);
        check("t2_packets", 128'(dut_order.size()), 128'(2));
        if (dut_order.size() == 2) begin
            check("t2_first", 128'(dut_order[0]), 128'(1));
            check("t2_second", 128'(dut_order[1]), 128'(2));
        end

        // Sources 0 and 3 keep requesting single-beat packets.
        do_reset();
        dut_order.delete();
        for (int k = 0; k < 4; k++) begin
            push_pkt(0, 1, 64'hC000 + 64'(k), 64'h0);
            push_pkt(3, 1, 64'hD000 + 64'(k), 64'h0);
        end
        drive();
        drain("t3_drain", 80);
        check("t3_packets", 128'(dut_order.size()), 128'(8));
        if (dut_order.size() == 8) begin
            for (int k = 0; k < 4; k++) check("t3_grant_order", 128'(dut_order[k]), 128'(exp3[k]));
        end

        // Eight-beat packet from source 2 against a 1,0,0,1 ready pattern.
        rdy_mode  = 1;
        out_count = 0;
        push_pkt(2, 8, 64'hE000, 64'h1);
        drive();
        drain("t4_drain", 100);
        check("t4_beats_out", 128'(out_count), 128'(8));

        // Reset during beat 2 of a five-beat packet, then a clean packet.
        rdy_mode   = 0;
        start_head = head[2];
        push_pkt(2, 5, 64'hF000, 64'h1);
        drive();
        n = 0;
        while (head[2] - start_head < 2 && n < 20) begin
            tick();
            n++;
        end
        check("t5_reach_beat2", 128'(n < 20), 128'(1));
        do_reset();
        @(negedge clk);
        check("t5_rst_m_valid", 128'(m_axis_tvalid), 128'(0));
        check("t5_rst_s_ready", 128'(s_axis_tready), 128'(0));
        check("t5_rst_grant", 128'(grant_index), 128'(0));
        check("t5_rst_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        dut_order.delete();
        push_pkt(1, 4, 64'h5100, 64'h1);
        drive();
        drain("t5_drain", 50);
        check("t5_packets", 128'(dut_order.size()), 128'(1));
        if (dut_order.size() == 1) check("t5_source", 128'(dut_order[0]), 128'(1));

        // Random packets on all sources with a random sink ready.
        rdy_mode = 2;
        for (int p = 0; p < 30; p++) begin
            push_pkt(int'($urandom_range(0, S - 1)), int'($urandom_range(1, 6)), {$urandom, $urandom}, 64'h1);
        end
        drive();
        drain("t6_drain", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
